// File: rtl/jt49_dcadd.sv
// jt49_dcadd: adds a ramped DC offset to a signed, DC-free audio sample so it
// can drive an unsigned DAC without pops on mute/unmute.
//
// Parameters:
//   sw         output sample width in bits
//   RAMP_SHIFT offset moves one LSB every 2^RAMP_SHIFT cen pulses
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-high reset, overrides cen
//   cen      sample-rate clock enable
//   mute     1 = ramp to silence, 0 = ramp to midscale and pass audio
//   din      signed audio sample (sw+1 bits)
//   dout     unsigned DAC sample (sw bits), registered
//   ready    high while in RUN
//   clip     high for the sample in which dout was saturated
//   clip_cnt saturating clip event counter
// Optional feature: define JT49_DCADD_CLIPCNT_EN to build the clip counter;
// otherwise clip_cnt is tied to zero.
module jt49_dcadd #(
  parameter int sw         = 8,
  parameter int RAMP_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic               mute,
  input  logic signed [sw:0] din,
  output logic [sw-1:0]      dout,
  output logic               ready,
  output logic               clip,
  output logic [15:0]        clip_cnt
);

  typedef enum logic [1:0] {
    MUTED  = 2'd0,
    RAMPUP = 2'd1,
    RUN    = 2'd2,
    RAMPDN = 2'd3
  } state_t;

  localparam logic [sw-1:0]         HALF      = sw'(1) << (sw-1);
  localparam logic [sw-1:0]         HALF_M1   = HALF - sw'(1);
  localparam logic [sw-1:0]         MAXV      = {sw{1'b1}};
  localparam logic [sw-1:0]         OFF_ONE   = sw'(1);
  localparam logic [RAMP_SHIFT-1:0] PRESC_ONE = RAMP_SHIFT'(1);

  state_t                state_r;
  logic [sw-1:0]         offset_r;
  logic [RAMP_SHIFT-1:0] presc_r;
  logic                  ramp_tick_s;
  logic [sw+1:0]         sum_s;
  logic [sw-1:0]         dout_s;
  logic                  clip_s;

  // prescaler all-ones on a cen cycle marks a ramp step
  assign ramp_tick_s = &presc_r;

  // next output sample: offset alone outside RUN, saturated din+offset in RUN
  always_comb begin
    sum_s  = {din[sw], din} + {2'b00, offset_r};
    dout_s = offset_r;
    clip_s = 1'b0;
    if (state_r == RUN) begin
      if (sum_s[sw+1]) begin
        // negative sum
        dout_s = {sw{1'b0}};
        clip_s = 1'b1;
      end else if (sum_s[sw]) begin
        // above full scale
        dout_s = MAXV;
        clip_s = 1'b1;
      end else begin
        dout_s = sum_s[sw-1:0];
        clip_s = 1'b0;
      end
    end else begin
      dout_s = offset_r;
      clip_s = 1'b0;
    end
  end

  // level FSM with offset ramp and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= MUTED;
      offset_r <= {sw{1'b0}};
      presc_r  <= {RAMP_SHIFT{1'b0}};
      dout     <= {sw{1'b0}};
      clip     <= 1'b0;
      ready    <= 1'b0;
    end else if (cen) begin
      dout <= dout_s;
      clip <= clip_s;
      case (state_r)
        MUTED: begin
          offset_r <= {sw{1'b0}};
          if (!mute) begin
            state_r <= RAMPUP;
            presc_r <= {RAMP_SHIFT{1'b0}};
          end
        end
        RAMPUP: begin
          if (mute) begin
            state_r <= RAMPDN;
            presc_r <= {RAMP_SHIFT{1'b0}};
          end else begin
            presc_r <= presc_r + PRESC_ONE;
            if (ramp_tick_s) begin
              offset_r <= offset_r + OFF_ONE;
              if (offset_r == HALF_M1) begin
                state_r <= RUN;
                ready   <= 1'b1;
                presc_r <= {RAMP_SHIFT{1'b0}};
              end
            end
          end
        end
        RUN: begin
          offset_r <= HALF;
          if (mute) begin
            state_r <= RAMPDN;
            ready   <= 1'b0;
            presc_r <= {RAMP_SHIFT{1'b0}};
          end
        end
        RAMPDN: begin
          if (!mute) begin
            state_r <= RAMPUP;
            presc_r <= {RAMP_SHIFT{1'b0}};
          end else begin
            presc_r <= presc_r + PRESC_ONE;
            if (ramp_tick_s) begin
              offset_r <= offset_r - OFF_ONE;
              if (offset_r == OFF_ONE) begin
                state_r <= MUTED;
                presc_r <= {RAMP_SHIFT{1'b0}};
              end
            end
          end
        end
        default: begin
          state_r  <= MUTED;
          offset_r <= {sw{1'b0}};
          presc_r  <= {RAMP_SHIFT{1'b0}};
          ready    <= 1'b0;
        end
      endcase
    end
  end

`ifdef JT49_DCADD_CLIPCNT_EN
  logic [15:0] clip_cnt_r;

  // saturating count of saturated output samples
  always_ff @(posedge clk) begin
    if (rst) begin
      clip_cnt_r <= 16'd0;
    end else if (cen && clip_s && (clip_cnt_r != 16'hFFFF)) begin
      clip_cnt_r <= clip_cnt_r + 16'd1;
    end
  end

  assign clip_cnt = clip_cnt_r;
`else
  assign clip_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_jt49_dcadd.sv
// Directed bench for jt49_dcadd with sw=8, RAMP_SHIFT=2.
module tb_jt49_dcadd;

  logic              clk;
  logic              rst;
  logic              cen;
  logic              mute;
  logic signed [8:0] din;
  logic [7:0]        dout;
  logic              ready;
  logic              clip;
  logic [15:0]       clip_cnt;

  int checks = 0;
  int errors = 0;
  int ccnt   = 0;
  int cen_div = 1;

  jt49_dcadd #(.sw(8), .RAMP_SHIFT(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .mute     (mute),
    .din      (din),
    .dout     (dout),
    .ready    (ready),
    .clip     (clip),
    .clip_cnt (clip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one clock; outputs sampled 1 time unit after the edge, cen set for the next edge
  task automatic tick();
    @(posedge clk);
    #1;
    ccnt++;
    cen = ((ccnt % cen_div) == 0);
  endtask

  // follow dout through nsteps changes, each must be prev+dir, spaced gap clocks
  task automatic ramp_track(input string tag, input int dir, input int nsteps,
                            input int gap, input int tmo);
    int prev;
    int last;
    int steps;
    int t;
    prev  = int'(dout);
    last  = -1;
    steps = 0;
    t     = 0;
    while (steps < nsteps && t < tmo) begin
      tick();
      t++;
      if (int'(dout) != prev) begin
        chk({tag, "_step"}, int'(dout), prev + dir);
        if (last >= 0) chk({tag, "_gap"}, t - last, gap);
        last = t;
        prev = int'(dout);
        steps++;
      end
    end
    if (steps < nsteps) chk({tag, "_timeout"}, steps, nsteps);
  endtask

  int din_v  [5] = '{-129, -128, 0, 127, 128};
  int dout_e [5] = '{0, 0, 128, 255, 255};
  int clip_e [5] = '{1, 0, 0, 0, 1};
  int cnt_e;

  initial begin
    rst  = 1'b1;
    cen  = 1'b1;
    mute = 1'b0;
    din  = 9'sd0;
    tick();
    tick();
    chk("rst_dout", int'(dout), 0);
    chk("rst_clip", int'(clip), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_clipcnt", int'(clip_cnt), 0);
    rst = 1'b0;

    // power-up ramp 0 -> 128, one step per 4 cen
    ramp_track("up", 1, 127, 4, 700);
    chk("up127_ready", int'(ready), 0);
    ramp_track("up_last", 1, 1, 4, 20);
    chk("run_ready", int'(ready), 1);
    for (int i = 0; i < 10; i++) tick();
    chk("run_hold", int'(dout), 128);

    // saturation corners around midscale
    for (int i = 0; i < 5; i++) begin
      din = 9'(din_v[i]);
      tick();
      chk($sformatf("sat_dout_%0d", din_v[i]), int'(dout), dout_e[i]);
      chk($sformatf("sat_clip_%0d", din_v[i]), int'(clip), clip_e[i]);
    end
    din = 9'sd0;
    tick();
`ifdef JT49_DCADD_CLIPCNT_EN
    cnt_e = 2;
`else
    cnt_e = 0;
`endif
    chk("clip_cnt", int'(clip_cnt), cnt_e);

    // ramp down from RUN, audio ignored
    mute = 1'b1;
    tick();
    chk("dn_ready", int'(ready), 0);
    chk("dn_first", int'(dout), 128);
    din = 9'sd100;
    ramp_track("dn", -1, 128, 4, 700);
    for (int i = 0; i < 10; i++) tick();
    chk("muted_dout", int'(dout), 0);
    chk("muted_clip", int'(clip), 0);
    din = 9'sd0;

    // reverse mid-ramp at 40 without a step
    mute = 1'b0;
    ramp_track("up40", 1, 40, 4, 400);
    chk("at40", int'(dout), 40);
    mute = 1'b1;
    ramp_track("rev", -1, 5, 4, 100);
    chk("rev_end", int'(dout), 35);

    // reset mid-ramp aborts to zero, ramp restarts
    mute = 1'b0;
    ramp_track("up_again", 1, 5, 4, 100);
    chk("at40b", int'(dout), 40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_dout", int'(dout), 0);
    chk("abort_ready", int'(ready), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("restart_hold0", int'(dout), 0);
    tick();
    chk("restart_first", int'(dout), 1);

    // cen 1-in-3: ramp counts cen pulses, dout holds in between
    cen_div = 3;
    ramp_track("slow", 1, 4, 12, 200);
    chk("slow_end", int'(dout), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt49_dcadd.md
JT49_DCADD -- requirements
Module: jt49_dcadd

Interface
REQ-001 SHALL have parameter sw, default 8: output sample width in bits.
REQ-002 SHALL have parameter RAMP_SHIFT, default 4: offset advances one LSB every 2^RAMP_SHIFT cen pulses.
REQ-003 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port cen  in  1  sample-rate clock enable; no state advances when low.
REQ-006 SHALL have port mute  in  1  level request: 1 = ramp to silence, 0 = ramp to midscale and pass audio.
REQ-007 SHALL have port din  in  sw+1  signed audio sample, DC-free.
REQ-008 SHALL have port dout  out  sw  unsigned DAC sample.
REQ-009 SHALL have port ready  out  1  high only in state RUN.
REQ-010 SHALL have port clip  out  1  high for the cen-sample in which dout was saturated.
REQ-011 SHALL have port clip_cnt  out  16  clip event count (see Configuration).

Function
REQ-012 SHALL keep an offset register of sw bits, range 0..2^(sw-1), and a RAMP_SHIFT-bit prescaler counting cen pulses; a ramp tick is cen high with prescaler all ones.
REQ-013 SHALL implement states MUTED, RAMPUP, RUN, RAMPDN, each transition occurring only on a cen cycle.
REQ-014 MUTED: offset 0, dout 0; mute=0 -> RAMPUP.
REQ-015 RAMPUP: offset +1 per ramp tick; the tick on which offset reaches 2^(sw-1) -> RUN; mute=1 -> RAMPDN from current offset, no jump.
REQ-016 RUN: offset held at 2^(sw-1); mute=1 -> RAMPDN.
REQ-017 RAMPDN: offset -1 per ramp tick; the tick on which offset reaches 0 -> MUTED; mute=0 -> RAMPUP from current offset.
REQ-018 SHALL reset the prescaler to 0 on every state transition.
REQ-019 In MUTED, RAMPUP and RAMPDN the audio term SHALL be forced to zero, so dout equals offset.
REQ-020 In RUN, sum = sign-extended din (sw+2 bits) + offset.
REQ-021 If sum < 0, dout SHALL be 0 with clip=1.
REQ-022 If sum > 2^sw-1, dout SHALL be 2^sw-1 with clip=1.
REQ-023 Otherwise dout SHALL be sum[sw-1:0] with clip=0.
REQ-024 dout and clip SHALL be registered and updated only when cen=1; latency is one cen-qualified clock from din to dout, and both hold between cen pulses.
REQ-025 Example with sw=8, offset 128: din=-129 gives dout 0 with clip; din=-128 gives 0 without clip; din=127 gives 255 without clip; din=128 gives 255 with clip.
REQ-026 A mute change between cen pulses SHALL be sampled only at the next cen.

Reset
REQ-027 rst SHALL override cen: state MUTED, offset 0, prescaler 0, dout 0, clip 0, ready 0, clip_cnt 0 on the next clock.
REQ-028 rst asserted mid-ramp or in RUN SHALL abort immediately to the REQ-027 values, with no ramp-down.

Configuration
REQ-029 With macro JT49_DCADD_CLIPCNT_EN defined, clip_cnt SHALL increment on each cen cycle that sets clip=1, saturate at 16'hFFFF, and clear only on rst.
REQ-030 Without JT49_DCADD_CLIPCNT_EN, clip_cnt SHALL be constant 0 and no counter logic SHALL be synthesised; all other behaviour is identical.

Verification (sw=8, RAMP_SHIFT=2, cen every clock)
REQ-031 rst, mute=0, din=0 -> dout 0,1,...,128 stepping every 4 cen; RUN/ready=1 after 512 cen; dout stays 128.
REQ-032 In RUN drive din -129, -128, 0, 127, 128 -> dout 0,0,128,255,255 one cen later; clip 1,0,0,0,1; clip_cnt=2 with macro, 0 without.
REQ-033 In RUN set mute=1 -> ready drops; dout ramps 128 down to 0 over 512 cen regardless of din; state MUTED.
REQ-034 During RAMPUP at offset 40, set mute=1 -> dout continues 40,39,... with no step.
REQ-035 During RAMPUP at offset 40, assert rst for one clock -> dout 0 next clock; ramp restarts from 0.
REQ-036 Drive cen 1-in-3 clocks -> ramp timing counts cen pulses only; dout holds between pulses.
